// File: rtl/display_frame_gen.sv
// Randomised segment-selection frame generator: one LFSR step per segment,
// complete frames handed downstream over a valid/ready handshake.
module display_frame_gen #(
   parameter int NB_SEGMENTS = 28,
   parameter int FRAME_CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [15:0]            seed,
   input  logic [NB_SEGMENTS-1:0] msg,
   input  logic                   z,
   input  logic [1:0]             prob_mode,
   input  logic [FRAME_CNT_W-1:0] nb_frames,
   output logic                   busy,
   output logic                   frame_valid,
   input  logic                   frame_ready,
   output logic [NB_SEGMENTS-1:0] frame_seg,
   output logic [FRAME_CNT_W-1:0] frame_idx,
   output logic                   done,
   output logic [1:0]             dbg_state_o
);

   localparam int SEG_W = $clog2(NB_SEGMENTS);
   localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NB_SEGMENTS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GEN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [15:0]            lfsr_q, lfsr_d;
   logic [SEG_W-1:0]       seg_cnt_q, seg_cnt_d;
   logic [NB_SEGMENTS-1:0] build_q, build_d;
   logic [NB_SEGMENTS-1:0] seg_q, seg_d;
   logic [FRAME_CNT_W-1:0] idx_q, idx_d;
   logic [NB_SEGMENTS-1:0] msg_q, msg_d;
   logic                   z_q, z_d;
   logic [1:0]             mode_q, mode_d;
   logic [FRAME_CNT_W-1:0] nb_q, nb_d;
   logic                   done_q, done_d;

   logic [15:0]            lfsr_nxt;
   logic [3:0]             thr;
   logic                   hit;
   logic                   seg_bit;
   logic [FRAME_CNT_W-1:0] idx_inc;
   logic                   is_last;

   // Handshake: a frame moves downstream on every rising clock edge where
   // frame_valid and frame_ready are both high; frame_seg/frame_idx are held
   // unchanged while frame_valid is high and frame_ready is low.
   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      seg_cnt_d = seg_cnt_q;
      build_d   = build_q;
      seg_d     = seg_q;
      idx_d     = idx_q;
      msg_d     = msg_q;
      z_d       = z_q;
      mode_d    = mode_q;
      nb_d      = nb_q;
      done_d    = 1'b0;

      lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      case (mode_q)
         2'b00:   thr = 4'd8;
         2'b01:   thr = 4'd11;
         2'b10:   thr = 4'd13;
         default: thr = 4'd14;
      endcase
      hit     = (lfsr_nxt[3:0] < thr);
      seg_bit = msg_q[seg_cnt_q] ? hit : (z_q & ~hit);
      idx_inc = idx_q + 1'b1;
      is_last = (nb_q != '0) && (idx_inc == nb_q);

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               lfsr_d    = (seed == 16'h0000) ? 16'h0001 : seed;
               msg_d     = msg;
               z_d       = z;
               mode_d    = prob_mode;
               nb_d      = nb_frames;
               seg_cnt_d = '0;
               idx_d     = '0;
               state_d   = S_GEN;
            end
         end
         S_GEN: begin
            lfsr_d            = lfsr_nxt;
            build_d[seg_cnt_q] = seg_bit;
            if (seg_cnt_q == LAST_SEG) begin
               // Publish the whole frame at once so frame_seg never shows a partial mask.
               seg_d     = build_d;
               seg_cnt_d = '0;
               state_d   = S_HOLD;
            end else begin
               seg_cnt_d = seg_cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (frame_ready) begin
               if (is_last) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_inc;
                  state_d = S_GEN;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         lfsr_q    <= 16'h0001;
         seg_cnt_q <= '0;
         build_q   <= '0;
         seg_q     <= '0;
         idx_q     <= '0;
         msg_q     <= '0;
         z_q       <= 1'b0;
         mode_q    <= 2'b00;
         nb_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lfsr_q    <= lfsr_d;
         seg_cnt_q <= seg_cnt_d;
         build_q   <= build_d;
         seg_q     <= seg_d;
         idx_q     <= idx_d;
         msg_q     <= msg_d;
         z_q       <= z_d;
         mode_q    <= mode_d;
         nb_q      <= nb_d;
         done_q    <= done_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign frame_valid = (state_q == S_HOLD);
   assign frame_seg   = seg_q;
   assign frame_idx   = idx_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_display_frame_gen.sv
// Directed bench for display_frame_gen (NB_SEGMENTS=4): frame-level model with
// an expected-frame queue, per-cycle frame compare and literal pins.
module tb_display_frame_gen;

   localparam int NB = 4;
   localparam int FW = 8;
   localparam int EW = NB + FW;

   logic          clk = 1'b0;
   logic          rst, start, abort, z, frame_ready;
   logic [15:0]   seed;
   logic [NB-1:0] msg;
   logic [1:0]    prob_mode;
   logic [FW-1:0] nb_frames;
   logic          busy, frame_valid, done;
   logic [NB-1:0] frame_seg;
   logic [FW-1:0] frame_idx;
   logic [1:0]    dbg_state;

   display_frame_gen #(.NB_SEGMENTS(NB), .FRAME_CNT_W(FW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
      .msg(msg), .z(z), .prob_mode(prob_mode), .nb_frames(nb_frames),
      .busy(busy), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .frame_seg(frame_seg), .frame_idx(frame_idx), .done(done),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   int            done_cnt = 0;
   logic [EW-1:0] exp_q[$];
   logic [FW-1:0] idx_hist[$];
   int            xfer_cyc[$];
   logic [NB-1:0] last_seg = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      int v;
      v = int'(s);
      return 16'((v << 1) | (((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1));
   endfunction

   // Expected frames of one run, from the segment rule applied to the LFSR sequence.
   task automatic load_model(input logic [15:0] sd, input logic [NB-1:0] m, input logic zz,
                             input logic [1:0] md, input int frames);
      int            thr[4] = '{8, 11, 13, 14};
      logic [15:0]   s;
      logic [NB-1:0] mask;
      logic          hit;
      exp_q.delete();
      s = (sd == 16'h0000) ? 16'h0001 : sd;
      for (int f = 0; f < frames; f++) begin
         mask = '0;
         for (int i = 0; i < NB; i++) begin
            s = lfsr_step(s);
            hit = (int'(s[3:0]) < thr[md]);
            mask[i] = m[i] ? hit : (zz && !hit);
         end
         exp_q.push_back({FW'(f), mask});
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (done === 1'b1) done_cnt++;
      if (frame_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got idx=%0d seg=%b, expected no frame", frame_idx, frame_seg);
         end else if ({frame_idx, frame_seg} !== exp_q[0]) begin
            errors++;
            $display("FAIL frame_cmp: got idx=%0d seg=%b expected idx=%0d seg=%b",
                     frame_idx, frame_seg, exp_q[0][EW-1:NB], exp_q[0][NB-1:0]);
         end
         if (frame_ready === 1'b1) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            idx_hist.push_back(frame_idx);
            xfer_cyc.push_back(cyc);
            last_seg = frame_seg;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start, then scramble every operating input to prove they were latched.
   task automatic run_start(input logic [15:0] sd, input logic [NB-1:0] m, input logic zz,
                            input logic [1:0] md, input logic [FW-1:0] nb, input int model_frames);
      load_model(sd, m, zz, md, model_frames);
      idx_hist.delete();
      xfer_cyc.delete();
      seed = sd; msg = m; z = zz; prob_mode = md; nb_frames = nb;
      start = 1'b1;
      tick();
      start = 1'b0;
      seed = ~sd; msg = ~m; z = ~zz; prob_mode = ~md; nb_frames = nb + 8'd1;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk({name, "_done_seen"}, 32'(done), 1);
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n = 0;
      while (frame_valid !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk({name, "_valid_seen"}, 32'(frame_valid), 1);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_busy"}, 32'(busy), 0);
      chk({name, "_valid"}, 32'(frame_valid), 0);
      chk({name, "_done"}, 32'(done), 0);
      chk({name, "_seg"}, 32'(frame_seg), 0);
      chk({name, "_idx"}, 32'(frame_idx), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int            lat;
      int            d0;
      int            n;
      logic          stable;
      logic          prev_busy;
      logic [EW-1:0] cap;

      rst = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; msg = '0; z = 1'b0;
      prob_mode = 2'b00; nb_frames = '0; frame_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      chk("reset_state", 32'(dbg_state), 0);
      rst = 1'b0;
      tick();

      // Single frame, mode 11: r = 2,4,8,0 all below 14.
      frame_ready = 1'b1;
      run_start(16'h0001, 4'hF, 1'b0, 2'b11, 8'd1, 1);
      lat = 1;
      while (frame_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      chk("t1_latency", lat, 5);
      chk("t1_seg", 32'(frame_seg), 32'b1111);
      chk("t1_idx", 32'(frame_idx), 0);
      tick();
      chk("t1_done", 32'(done), 1);
      chk("t1_busy_low", 32'(busy), 0);
      chk("t1_valid_low", 32'(frame_valid), 0);
      tick();
      chk("t1_done_single", 32'(done), 0);

      run_start(16'h0001, 4'hF, 1'b0, 2'b00, 8'd1, 1);
      wait_done("t2", 20);
      chk("t2_seg", 32'(last_seg), 32'b1011);
      tick();

      run_start(16'h0001, 4'h0, 1'b1, 2'b00, 8'd1, 1);
      wait_done("t3", 20);
      chk("t3_seg", 32'(last_seg), 32'b0100);
      tick();

      run_start(16'h0001, 4'h0, 1'b0, 2'b00, 8'd1, 1);
      wait_done("t4", 20);
      chk("t4_seg", 32'(last_seg), 32'b0000);
      tick();

      run_start(16'h0000, 4'hF, 1'b0, 2'b00, 8'd1, 1);
      wait_done("t5_seed0", 20);
      chk("t5_seed0_seg", 32'(last_seg), 32'b1011);
      tick();
      run_start(16'h0000, 4'b1001, 1'b1, 2'b01, 8'd6, 6);
      wait_done("t5_seed0_multi", 60);
      chk("t5_seed0_q_empty", exp_q.size(), 0);
      tick();

      // Three frames with a 10-cycle stall on frame 1.
      frame_ready = 1'b0;
      run_start(16'hACE1, 4'b1010, 1'b1, 2'b01, 8'd3, 3);
      wait_valid("t6_f0", 20);
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      wait_valid("t6_f1", 20);
      cap = {frame_idx, frame_seg};
      stable = 1'b1;
      repeat (10) begin
         tick();
         if (frame_valid !== 1'b1 || {frame_idx, frame_seg} !== cap) stable = 1'b0;
      end
      chk("t6_stall_stable", 32'(stable), 1);
      chk("t6_stall_idx", 32'(cap[EW-1:NB]), 1);
      frame_ready = 1'b1;
      d0 = done_cnt;
      n = 0;
      prev_busy = busy;
      while (done !== 1'b1 && n < 40) begin
         prev_busy = busy;
         tick();
         n++;
      end
      chk("t6_done_seen", 32'(done), 1);
      chk("t6_busy_with_done", 32'(busy), 0);
      chk("t6_busy_before_done", 32'(prev_busy), 1);
      repeat (5) tick();
      chk("t6_one_done", done_cnt - d0, 1);
      chk("t6_nframes", idx_hist.size(), 3);
      chk("t6_idx0", 32'(idx_hist[0]), 0);
      chk("t6_idx1", 32'(idx_hist[1]), 1);
      chk("t6_idx2", 32'(idx_hist[2]), 2);
      chk("t6_q_empty", exp_q.size(), 0);

      // Continuous mode, 300 back-to-back frames, then abort mid-GEN.
      frame_ready = 1'b1;
      d0 = done_cnt;
      run_start(16'h1234, 4'b0110, 1'b1, 2'b10, 8'd0, 302);
      n = 0;
      while (idx_hist.size() < 300 && n < 2000) begin
         tick();
         n++;
      end
      chk("t7_300_frames", 32'(idx_hist.size() >= 300), 1);
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t7_abort_busy", 32'(busy), 0);
      chk("t7_abort_valid", 32'(frame_valid), 0);
      chk("t7_abort_done", 32'(done), 0);
      chk("t7_abort_state", 32'(dbg_state), 0);
      repeat (8) tick();
      chk("t7_no_done", done_cnt - d0, 0);
      chk("t7_idle_valid", 32'(frame_valid), 0);
      chk("t7_idx255", 32'(idx_hist[255]), 255);
      chk("t7_idx_wrap", 32'(idx_hist[256]), 0);
      chk("t7_idx299", 32'(idx_hist[299]), 43);
      chk("t7_spacing", xfer_cyc[299] - xfer_cyc[0], 299 * 5);
      exp_q.delete();

      // abort together with start in IDLE: start ignored.
      seed = 16'h0001; msg = 4'hF; nb_frames = 8'd1;
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("t8_abort_start_busy", 32'(busy), 0);
      tick();
      chk("t8_abort_start_busy2", 32'(busy), 0);

      // Reset mid-GEN, then a start one cycle after release.
      run_start(16'h00FF, 4'hF, 1'b0, 2'b00, 8'd2, 2);
      tick();
      rst = 1'b1;
      #1;
      chk_all_zero("t9_rst_gen");
      tick();
      rst = 1'b0;
      exp_q.delete();
      tick();
      run_start(16'h0001, 4'hF, 1'b0, 2'b11, 8'd1, 1);
      wait_done("t9_after_rst", 20);
      chk("t9_after_rst_seg", 32'(last_seg), 32'b1111);
      chk("t9_q_empty", exp_q.size(), 0);
      tick();

      // Reset mid-HOLD.
      frame_ready = 1'b0;
      run_start(16'hBEEF, 4'b0011, 1'b1, 2'b10, 8'd1, 1);
      wait_valid("t10_hold", 20);
      rst = 1'b1;
      #1;
      chk_all_zero("t10_rst_hold");
      tick();
      rst = 1'b0;
      exp_q.delete();
      frame_ready = 1'b1;
      tick();

      // Start while busy must change nothing.
      run_start(16'h0001, 4'hF, 1'b0, 2'b00, 8'd2, 2);
      tick();
      seed = 16'h5555; msg = 4'h0; z = 1'b1; prob_mode = 2'b11; nb_frames = 8'd5;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done("t11_busy_start", 40);
      chk("t11_nframes", idx_hist.size(), 2);
      chk("t11_q_empty", exp_q.size(), 0);
      tick();
      chk("t11_idle", 32'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
